eh2_bht_ghr_tracker: RTL

EH2_BHT_GHR_TRACKER -- requirements
Module: eh2_bht_ghr_tracker

---
 rtl/eh2_bht_ghr_tracker.sv | 86 ++++++++
 1 files changed

// File: rtl/eh2_bht_ghr_tracker.sv
// Speculative global-history tracker with a circular checkpoint buffer.
// Mispredict recovery rebuilds history from a checkpoint; retirement builds the architectural copy.
module eh2_bht_ghr_tracker #(
  parameter int GHR_SIZE   = 8,
  parameter int CKPT_DEPTH = 4,
  localparam int PW        = $clog2(CKPT_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid,
  input  logic                pred_taken,
  output logic                pred_ready,
  output logic [PW-1:0]       pred_id,
  input  logic                mp_valid,
  input  logic [PW-1:0]       mp_id,
  input  logic                mp_taken,
  input  logic                ret_valid,
  input  logic                ret_taken,
  input  logic                flush_all,
  output logic [GHR_SIZE-1:0] ghr,
  output logic [GHR_SIZE-1:0] ghr_arch,
  output logic [PW:0]         count
);

  localparam logic [PW:0] ONE  = (PW+1)'(1);
  localparam logic [PW:0] FULL = (PW+1)'(CKPT_DEPTH);

  logic [GHR_SIZE-1:0] ckpt [CKPT_DEPTH];
  logic [PW:0]         wp_x;
  logic [PW:0]         rp_x;
  logic [PW:0]         wp_x_next;
  logic [PW:0]         rp_x_next;
  logic [GHR_SIZE-1:0] ghr_next;
  logic [GHR_SIZE-1:0] ghr_arch_next;
  logic [PW-1:0]       mp_offset;
  logic                ret_fire;
  logic                pred_fire;

  // Pointers carry one extra wrap bit so a full buffer is distinguishable from an empty one.
  assign count      = wp_x - rp_x;
  assign pred_ready = (count != FULL);
  assign pred_id    = wp_x[PW-1:0];

  assign ret_fire   = ret_valid && (count != '0);
  assign pred_fire  = pred_valid && pred_ready && !mp_valid && !flush_all;
  assign mp_offset  = mp_id - rp_x[PW-1:0];

  always_comb begin
    rp_x_next     = ret_fire ? rp_x + ONE : rp_x;
    ghr_arch_next = ret_fire ? {ghr_arch[GHR_SIZE-2:0], ret_taken} : ghr_arch;
    ghr_next      = ghr;
    wp_x_next     = wp_x;
    if (flush_all) begin
      ghr_next  = ghr_arch_next;
      wp_x_next = rp_x_next;
    end else if (mp_valid) begin
      // The mispredicted entry stays outstanding, so wp lands one past it relative to rp.
      ghr_next  = {ckpt[mp_id][GHR_SIZE-2:0], mp_taken};
      wp_x_next = rp_x + {1'b0, mp_offset} + ONE;
    end else if (pred_fire) begin
      ghr_next  = {ghr[GHR_SIZE-2:0], pred_taken};
      wp_x_next = wp_x + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr      <= '0;
      ghr_arch <= '0;
      wp_x     <= '0;
      rp_x     <= '0;
    end else begin
      ghr      <= ghr_next;
      ghr_arch <= ghr_arch_next;
      wp_x     <= wp_x_next;
      rp_x     <= rp_x_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && pred_fire) begin
      ckpt[wp_x[PW-1:0]] <= ghr;
    end
  end

endmodule
